// File: rtl/fir_sequencer.sv
// Sample-rate controller for the 128-tap serial-MAC FIR: buffers samples, drives
// tap-aligned ready bursts and hands each frame result out on a valid/ready port.
module fir_sequencer #(
   parameter int unsigned WIDTH      = 20,
   parameter int unsigned TAPS       = 128,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic signed [WIDTH-1:0] s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic signed [WIDTH-1:0] m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic signed [WIDTH-1:0] fir_in,
   output logic                    fir_ready,
   input  logic signed [WIDTH-1:0] fir_out,
   output logic                    busy
);

   localparam int unsigned PH_W = $clog2(TAPS);
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW   = AW + 1;

   typedef enum logic [2:0] {
      S_RESET,
      S_PRIME,
      S_IDLE,
      S_BURST,
      S_CAPTURE
   } state_t;

   state_t                  r_state;
   logic [PH_W-1:0]         r_phase;
   logic signed [WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]           r_wr_ptr;
   logic [AW-1:0]           r_rd_ptr;
   logic [CW-1:0]           r_count;
   logic                    r_s_ready;
   logic                    r_m_valid;
   logic signed [WIDTH-1:0] r_m_data;
   logic signed [WIDTH-1:0] r_fir_in;
   logic                    r_fir_ready;
   logic                    r_busy;
   logic                    r_pending;

   state_t                  w_state_nxt;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_load;
   logic                    w_pending_nxt;
   logic                    w_empty;
   logic                    w_out_free;
   logic signed [WIDTH-1:0] w_head;
   logic [CW-1:0]           w_count_nxt;
   logic                    w_s_ready_nxt;
   logic                    w_m_valid_nxt;
   logic signed [WIDTH-1:0] w_m_data_nxt;
   logic signed [WIDTH-1:0] w_fir_in_nxt;
   logic                    w_fir_ready_nxt;
   logic                    w_busy_nxt;

   assign w_push      = s_valid && r_s_ready;
   assign w_empty     = (r_count == '0);
   assign w_out_free  = !r_m_valid || m_ready;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   // Next state plus next values of every registered output
   always_comb begin
      w_state_nxt   = r_state;
      w_pop         = 1'b0;
      w_load        = 1'b0;
      w_pending_nxt = r_pending;
      case (r_state)
         S_RESET: w_state_nxt = S_PRIME;
         S_PRIME: w_state_nxt = S_IDLE;
         S_IDLE: begin
            if (enable && !w_empty) w_state_nxt = S_BURST;
         end
         S_BURST: begin
            if (r_phase == PH_W'(TAPS - 1)) begin
               w_pop         = 1'b1;
               w_load        = w_out_free;
               w_pending_nxt = !w_out_free;
               w_state_nxt   = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            // A result still waiting on the consumer keeps the filter frozen here
            if (!r_pending || w_out_free) begin
               w_load        = r_pending;
               w_pending_nxt = 1'b0;
               w_state_nxt   = (enable && !w_empty) ? S_BURST : S_IDLE;
            end
         end
         default: w_state_nxt = S_RESET;
      endcase

      w_fir_ready_nxt = (w_state_nxt == S_PRIME) || (w_state_nxt == S_BURST);
      w_fir_in_nxt    = '0;
      if (w_state_nxt == S_BURST) w_fir_in_nxt = (r_state == S_BURST) ? r_fir_in : w_head;
      w_busy_nxt      = (w_state_nxt != S_IDLE) && (w_state_nxt != S_RESET);
      w_s_ready_nxt   = (w_state_nxt != S_RESET) && (w_state_nxt != S_PRIME) &&
                        (w_count_nxt != CW'(FIFO_DEPTH));
      w_m_valid_nxt   = r_m_valid && !m_ready;
      w_m_data_nxt    = r_m_data;
      if (w_load) begin
         w_m_valid_nxt = 1'b1;
         w_m_data_nxt  = fir_out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_RESET;
         r_phase     <= PH_W'(TAPS - 1);
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_s_ready   <= 1'b0;
         r_m_valid   <= 1'b0;
         r_m_data    <= '0;
         r_fir_in    <= '0;
         r_fir_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_pending   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         if (r_fir_ready) r_phase <= r_phase + PH_W'(1);
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count     <= w_count_nxt;
         r_s_ready   <= w_s_ready_nxt;
         r_m_valid   <= w_m_valid_nxt;
         r_m_data    <= w_m_data_nxt;
         r_fir_in    <= w_fir_in_nxt;
         r_fir_ready <= w_fir_ready_nxt;
         r_busy      <= w_busy_nxt;
         r_pending   <= w_pending_nxt;
      end
   end

   // Sample storage carries no reset; stale entries are unreachable once pointers clear
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= s_data;
   end

   assign s_ready   = r_s_ready;
   assign m_valid   = r_m_valid;
   assign m_data    = r_m_data;
   assign fir_in    = r_fir_in;
   assign fir_ready = r_fir_ready;
   assign busy      = r_busy;

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: reset/prime, latency, streaming, backpressure,
// enable gating and mid-burst reset, observed on the falling edge.
module tb_fir_sequencer;

   localparam int unsigned WIDTH = 20;

   logic                    clk;
   logic                    rst_n;
   logic                    enable;
   logic signed [WIDTH-1:0] s_data;
   logic                    s_valid;
   logic                    s_ready;
   logic signed [WIDTH-1:0] m_data;
   logic                    m_valid;
   logic                    m_ready;
   logic signed [WIDTH-1:0] fir_in;
   logic                    fir_ready;
   logic signed [WIDTH-1:0] fir_out;
   logic                    busy;

   int n_checks;
   int n_pass;

   fir_sequencer #(.WIDTH(WIDTH), .TAPS(128), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .fir_in(fir_in), .fir_ready(fir_ready), .fir_out(fir_out),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
      m_ready = 1'b0; fir_out = '0;
      repeat (5) @(negedge clk);
      n_checks++; if ({s_ready, m_valid, fir_ready, busy} !== 4'b0000) $display("FAIL rst_flags: got %b expected 0000", {s_ready, m_valid, fir_ready, busy}); else n_pass++;
      n_checks++; if (m_data !== 20'sh0) $display("FAIL rst_m_data: got %h expected 00000", m_data); else n_pass++;
      n_checks++; if (fir_in !== 20'sh0) $display("FAIL rst_fir_in: got %h expected 00000", fir_in); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (fir_ready !== 1'b1) $display("FAIL prime_ready: got %b expected 1", fir_ready); else n_pass++;
      n_checks++; if (fir_in !== 20'sh0) $display("FAIL prime_fir_in: got %h expected 00000", fir_in); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL prime_busy: got %b expected 1", busy); else n_pass++;
      n_checks++; if (s_ready !== 1'b0) $display("FAIL prime_s_ready: got %b expected 0", s_ready); else n_pass++;
      @(negedge clk);
      n_checks++; if (fir_ready !== 1'b0) $display("FAIL post_prime_ready: got %b expected 0", fir_ready); else n_pass++;
      n_checks++; if (s_ready !== 1'b1) $display("FAIL post_prime_s_ready: got %b expected 1", s_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL post_prime_busy: got %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_single();
      int fr_bad, fin_bad;
      fr_bad = 0; fin_bad = 0;
      enable = 1'b1; m_ready = 1'b1; fir_out = 20'sh12345;
      s_data = 20'sh00100; s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      n_checks++; if (fir_ready !== 1'b0) $display("FAIL single_idle_cycle: got %b expected 0", fir_ready); else n_pass++;
      for (int k = 1; k <= 130; k++) begin
         @(negedge clk);
         if (k <= 128) begin
            if (fir_ready !== 1'b1) fr_bad++;
            if (fir_in !== 20'sh00100) fin_bad++;
            if (k == 128) begin
               n_checks++; if (m_valid !== 1'b0) $display("FAIL single_early_valid: got %b expected 0", m_valid); else n_pass++;
            end
         end else if (k == 129) begin
            n_checks++; if (fir_ready !== 1'b0) $display("FAIL single_burst_end: got %b expected 0", fir_ready); else n_pass++;
            n_checks++; if (m_valid !== 1'b1) $display("FAIL single_m_valid: got %b expected 1", m_valid); else n_pass++;
            n_checks++; if (m_data !== 20'sh12345) $display("FAIL single_m_data: got %h expected 12345", m_data); else n_pass++;
         end else begin
            n_checks++; if (m_valid !== 1'b0) $display("FAIL single_handshake: got %b expected 0", m_valid); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b expected 0", busy); else n_pass++;
         end
      end
      n_checks++; if (fr_bad !== 0) $display("FAIL single_ready_run: got %0d bad cycles expected 0", fr_bad); else n_pass++;
      n_checks++; if (fin_bad !== 0) $display("FAIL single_fir_in: got %0d bad cycles expected 0", fin_bad); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic signed [WIDTH-1:0] samp [5];
      logic signed [WIDTH-1:0] resp [5];
      int starts [5];
      int lens [5];
      int mv_t [5];
      logic signed [WIDTH-1:0] mv_d [5];
      int nb, nm, push5_at, fin_bad, pc, t_bad, d_bad;
      logic sr_at3, hs, prev;
      samp = '{20'sd1000, -20'sd1000, 20'sd0, 20'sd65535, -20'sd5};
      resp = '{20'sh0A001, 20'sh7FFFF, 20'sh00007, 20'shFFFFB, 20'sh3C3C3};
      for (int i = 0; i < 5; i++) begin starts[i] = 0; lens[i] = 0; mv_t[i] = 0; mv_d[i] = '0; end
      nb = 0; nm = 0; push5_at = -1; fin_bad = 0; pc = -1; sr_at3 = 1'bx; prev = 1'b0;
      enable = 1'b1; m_ready = 1'b1;
      fork
         begin : pusher
            for (int i = 0; i < 5; i++) begin
               s_data = samp[i]; s_valid = 1'b1;
               for (int w = 0; w < 400; w++) begin
                  hs = s_ready;
                  @(negedge clk);
                  pc++;
                  if (hs) begin
                     if (i == 4) push5_at = pc;
                     break;
                  end
               end
            end
            s_valid = 1'b0;
         end
         begin : monitor
            for (int c = 0; c <= 660; c++) begin
               @(negedge clk);
               if (c == 3) sr_at3 = s_ready;
               if (fir_ready && !prev) begin
                  if (nb < 5) begin starts[nb] = c; fir_out = resp[nb]; end
                  nb++;
               end
               if (fir_ready && nb >= 1 && nb <= 5) begin
                  lens[nb-1]++;
                  if (fir_in !== samp[nb-1]) fin_bad++;
               end
               if (m_valid) begin
                  if (nm < 5) begin mv_t[nm] = c; mv_d[nm] = m_data; end
                  nm++;
               end
               prev = fir_ready;
            end
         end
      join
      n_checks++; if (sr_at3 !== 1'b0) $display("FAIL b2b_full_s_ready: got %b expected 0", sr_at3); else n_pass++;
      n_checks++; if (push5_at !== 130) $display("FAIL b2b_push5_edge: got %0d expected 130", push5_at); else n_pass++;
      n_checks++; if (nb !== 5) $display("FAIL b2b_burst_count: got %0d expected 5", nb); else n_pass++;
      n_checks++; if (nm !== 5) $display("FAIL b2b_result_count: got %0d expected 5", nm); else n_pass++;
      t_bad = 0; d_bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (starts[i] !== 1 + 129 * i) t_bad++;
         if (lens[i] !== 128) t_bad++;
         if (mv_t[i] !== 129 + 129 * i) t_bad++;
         if (mv_d[i] !== resp[i]) d_bad++;
      end
      n_checks++; if (t_bad !== 0) $display("FAIL b2b_timing: got %0d bad slots expected 0 (first start %0d len %0d valid %0d)", t_bad, starts[0], lens[0], mv_t[0]); else n_pass++;
      n_checks++; if (d_bad !== 0) $display("FAIL b2b_m_data: got %0d bad results expected 0 (first %h vs %h)", d_bad, mv_d[0], resp[0]); else n_pass++;
      n_checks++; if (fin_bad !== 0) $display("FAIL b2b_fir_in: got %0d bad cycles expected 0", fin_bad); else n_pass++;
   endtask

   task automatic test_backpressure();
      int stall_bad;
      stall_bad = 0;
      m_ready = 1'b0; enable = 1'b1; fir_out = 20'sh11111;
      s_data = 20'sh00AAA; s_valid = 1'b1;
      @(negedge clk);
      s_data = 20'sh00BBB;
      @(negedge clk);
      s_valid = 1'b0;
      for (int c = 2; c <= 561; c++) begin
         @(negedge clk);
         if (c == 129) begin
            n_checks++; if (m_data !== 20'sh11111 || m_valid !== 1'b1) $display("FAIL bp_first_result: got %b/%h expected 1/11111", m_valid, m_data); else n_pass++;
         end
         if (c == 130) fir_out = 20'sh22222;
         if (c == 257) begin
            n_checks++; if (fir_ready !== 1'b1 || fir_in !== 20'sh00BBB) $display("FAIL bp_second_burst: got %b/%h expected 1/00bbb", fir_ready, fir_in); else n_pass++;
         end
         if (c >= 258 && c <= 559) begin
            if (fir_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 20'sh11111 || busy !== 1'b1) stall_bad++;
         end
         if (c == 559) m_ready = 1'b1;
         if (c == 560) begin
            n_checks++; if (m_valid !== 1'b1 || m_data !== 20'sh22222) $display("FAIL bp_reload: got %b/%h expected 1/22222", m_valid, m_data); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL bp_idle_after: got %b expected 0", busy); else n_pass++;
         end
         if (c == 561) begin
            n_checks++; if (m_valid !== 1'b0) $display("FAIL bp_drain: got %b expected 0", m_valid); else n_pass++;
         end
      end
      n_checks++; if (stall_bad !== 0) $display("FAIL bp_stall: got %0d bad cycles expected 0", stall_bad); else n_pass++;
   endtask

   task automatic test_enable();
      int idle_bad, fr_cnt, first, last, late_bad;
      idle_bad = 0; fr_cnt = 0; first = -1; last = -1; late_bad = 0;
      enable = 1'b0; m_ready = 1'b1; fir_out = 20'sh0CAFE;
      s_data = 20'sh00111; s_valid = 1'b1;
      @(negedge clk);
      s_data = 20'sh00222;
      @(negedge clk);
      s_valid = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (fir_ready !== 1'b0 || busy !== 1'b0) idle_bad++;
      end
      n_checks++; if (idle_bad !== 0) $display("FAIL en_gated: got %0d active cycles expected 0", idle_bad); else n_pass++;
      enable = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (c == 51) enable = 1'b0;
         if (fir_ready === 1'b1) begin
            fr_cnt++;
            if (first < 0) first = c;
            last = c;
            if (fir_in !== 20'sh00111) late_bad++;
         end
         if (c == 129) begin
            n_checks++; if (m_valid !== 1'b1 || m_data !== 20'sh0CAFE) $display("FAIL en_result: got %b/%h expected 1/0cafe", m_valid, m_data); else n_pass++;
         end
         if (c == 130) begin
            n_checks++; if (busy !== 1'b0) $display("FAIL en_to_idle: got %b expected 0", busy); else n_pass++;
         end
      end
      n_checks++; if (fr_cnt !== 128 || first !== 1 || last !== 128) $display("FAIL en_burst: got %0d cycles from %0d to %0d expected 128 from 1 to 128", fr_cnt, first, last); else n_pass++;
      n_checks++; if (late_bad !== 0) $display("FAIL en_fir_in: got %0d bad cycles expected 0", late_bad); else n_pass++;
   endtask

   task automatic test_mid_reset();
      int fr_cnt;
      fr_cnt = 0;
      enable = 1'b1; m_ready = 1'b1; fir_out = 20'sh01234;
      for (int c = 1; c <= 51; c++) @(negedge clk);
      n_checks++; if (fir_ready !== 1'b1 || fir_in !== 20'sh00222) $display("FAIL mr_in_burst: got %b/%h expected 1/00222", fir_ready, fir_in); else n_pass++;
      n_checks++; if (m_data !== 20'sh0CAFE) $display("FAIL mr_pre_m_data: got %h expected 0cafe", m_data); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({s_ready, m_valid, fir_ready, busy} !== 4'b0000) $display("FAIL mr_async_flags: got %b expected 0000", {s_ready, m_valid, fir_ready, busy}); else n_pass++;
      n_checks++; if (m_data !== 20'sh0 || fir_in !== 20'sh0) $display("FAIL mr_async_data: got %h/%h expected 00000/00000", m_data, fir_in); else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (fir_ready !== 1'b1 || fir_in !== 20'sh0) $display("FAIL mr_prime: got %b/%h expected 1/00000", fir_ready, fir_in); else n_pass++;
      @(negedge clk);
      n_checks++; if (s_ready !== 1'b1) $display("FAIL mr_s_ready: got %b expected 1", s_ready); else n_pass++;
      for (int c = 0; c < 200; c++) begin
         if (fir_ready === 1'b1) fr_cnt++;
         @(negedge clk);
      end
      n_checks++; if (fr_cnt !== 0 || busy !== 1'b0) $display("FAIL mr_fifo_empty: got %0d ready cycles busy %b expected 0 and 0", fr_cnt, busy); else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_enable();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
